pipe_ctrl: RTL and testbench

Pipeline stall/flush controller for the five-stage MIPS32 core. Collects stall requests from IF, ID (load-use hazard), EX (multi-cycle ops) and MEM, and produces the per-stage stall vector consumed by the PC register and every pipeline latch. Sequences exception and ERET redirects through a one-cycle freeze followed by a one-cycle flush, and drives the PC redirect. Optionally watches for stalls that never release.

---
 rtl/pipe_ctrl_if.sv | 36 +++
 rtl/pipe_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_if.sv
// ============================================================================
// pipe_ctrl_if : stall-request / redirect bundle between pipeline and pipe_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipe_ctrl_if;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        excp_req;
  logic [31:0] excp_vec;
  logic        eret_req;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        new_pc_valid;
  logic        busy;
  logic        timeout_err;

  modport master (
    output stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    output excp_req, excp_vec, eret_req, epc,
    input  stall, flush, new_pc, new_pc_valid, busy, timeout_err
  );

  modport slave (
    input  stallreq_if, stallreq_id, stallreq_ex, stallreq_mem,
    input  excp_req, excp_vec, eret_req, epc,
    output stall, flush, new_pc, new_pc_valid, busy, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// pipe_ctrl : stall vector + exception/ERET freeze/flush/redirect sequencer.
// Optional stall watchdog: define PIPE_STALL_WDOG_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module pipe_ctrl #(
  parameter int STALL_TIMEOUT = 255
) (
  input  wire logic   clk,
  input  wire logic   rst,
  pipe_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FREEZE = 2'd1,
    FLUSH  = 2'd2
  } state_t;

  localparam logic [5:0] C_STALL_ALL = 6'b111111;

  if (STALL_TIMEOUT < 1 || STALL_TIMEOUT > 65535) begin : g_timeout_range
    $error("pipe_ctrl: STALL_TIMEOUT out of range 1..65535");
  end

  state_t      r_state;
  state_t      w_next;
  logic [5:0]  w_stall;
  logic        w_accept;
  logic [31:0] w_target;
  logic [31:0] r_target;
  logic        r_flush;
  logic [31:0] r_new_pc;
  logic        r_new_pc_valid;
  logic        r_busy;

  always_comb begin
    w_next   = r_state;
    w_stall  = 6'b000000;
    w_accept = 1'b0;
    w_target = r_target;
    case (r_state)
      RUN: begin
        if (bus.excp_req || bus.eret_req) begin
          // Freeze every stage on the acceptance cycle so nothing commits.
          w_accept = 1'b1;
          w_stall  = C_STALL_ALL;
          w_target = bus.excp_req ? bus.excp_vec : bus.epc;
          w_next   = FREEZE;
        end else if (bus.stallreq_mem) begin
          w_stall = 6'b011111;
        end else if (bus.stallreq_ex) begin
          w_stall = 6'b001111;
        end else if (bus.stallreq_id) begin
          w_stall = 6'b000111;
        end else if (bus.stallreq_if) begin
          w_stall = 6'b000011;
        end
      end
      FREEZE: begin
        w_stall = C_STALL_ALL;
        w_next  = FLUSH;
      end
      FLUSH: begin
        w_next = RUN;
      end
      default: begin
        w_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= RUN;
      r_target       <= 32'd0;
      r_flush        <= 1'b0;
      r_new_pc       <= 32'd0;
      r_new_pc_valid <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_target       <= w_target;
      r_flush        <= (w_next == FLUSH);
      r_new_pc_valid <= (w_next == FLUSH);
      r_busy         <= (w_next != RUN);
      if (w_next == FLUSH) begin
        r_new_pc <= r_target;
      end
    end
  end

  assign bus.stall        = w_stall;
  assign bus.flush        = r_flush;
  assign bus.new_pc       = r_new_pc;
  assign bus.new_pc_valid = r_new_pc_valid;
  assign bus.busy         = r_busy;

`ifdef PIPE_STALL_WDOG_EN
  localparam logic [15:0] C_TIMEOUT = 16'(STALL_TIMEOUT);

  logic [15:0] r_wdog_cnt;
  logic [15:0] w_wdog_next;
  logic        r_timeout;

  always_comb begin
    w_wdog_next = r_wdog_cnt;
    if (w_accept || w_stall == 6'b000000) begin
      w_wdog_next = 16'd0;
    end else if (r_state == RUN && r_wdog_cnt != C_TIMEOUT) begin
      w_wdog_next = r_wdog_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog_cnt <= 16'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_wdog_cnt <= w_wdog_next;
      r_timeout  <= r_timeout | (w_wdog_next == C_TIMEOUT);
    end
  end

  assign bus.timeout_err = r_timeout;
`else
  assign bus.timeout_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// tb_pipe_ctrl : directed, table-driven self-checking bench for pipe_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

`ifdef PIPE_STALL_WDOG_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.STALL_TIMEOUT(TB_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       s_if;
    logic       s_id;
    logic       s_ex;
    logic       s_mem;
    logic [5:0] exp_stall;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_reqs(input logic a, input logic b, input logic c, input logic d);
    bus.stallreq_if  = a;
    bus.stallreq_id  = b;
    bus.stallreq_ex  = c;
    bus.stallreq_mem = d;
  endtask

  task automatic clear_all();
    set_reqs(1'b0, 1'b0, 1'b0, 1'b0);
    bus.excp_req = 1'b0;
    bus.eret_req = 1'b0;
    bus.excp_vec = 32'd0;
    bus.epc      = 32'd0;
  endtask

  // Full accept -> FREEZE -> FLUSH -> RUN sequence with checks at each cycle.
  task automatic redirect(input logic ex, input logic [31:0] vec, input logic er,
                          input logic [31:0] ep, input logic [31:0] exp_pc,
                          input logic [31:0] old_pc);
    @(negedge clk);
    bus.excp_req = ex; bus.excp_vec = vec;
    bus.eret_req = er; bus.epc      = ep;
    bus.stallreq_if = 1'b1;
    #1;
    check("accept_stall", 32'(bus.stall), 32'h3f);
    check("accept_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    clear_all();
    #1;
    check("freeze_stall", 32'(bus.stall), 32'h3f);
    check("freeze_busy", 32'(bus.busy), 32'd1);
    check("freeze_flush", 32'(bus.flush), 32'd0);
    check("freeze_npv", 32'(bus.new_pc_valid), 32'd0);
    check("freeze_newpc_hold", bus.new_pc, old_pc);
    @(negedge clk);
    #1;
    check("flush_stall", 32'(bus.stall), 32'd0);
    check("flush_flush", 32'(bus.flush), 32'd1);
    check("flush_npv", 32'(bus.new_pc_valid), 32'd1);
    check("flush_newpc", bus.new_pc, exp_pc);
    check("flush_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    #1;
    check("run_flush", 32'(bus.flush), 32'd0);
    check("run_npv", 32'(bus.new_pc_valid), 32'd0);
    check("run_busy", 32'(bus.busy), 32'd0);
    check("run_newpc_hold", bus.new_pc, exp_pc);
  endtask

  // Hold stallreq_if for n rising edges, then release.
  task automatic hold_if(input int n);
    @(negedge clk);
    bus.stallreq_if = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    bus.stallreq_if = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000011};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000111};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b001111};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b011111};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b011111};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000111};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b001111};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000111};
    vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b011111};

    rst = 1'b0;
    clear_all();
    #1;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_flush", 32'(bus.flush), 32'd0);
    check("rst_newpc", bus.new_pc, 32'd0);
    check("rst_npv", 32'(bus.new_pc_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Watchdog: 3 stalled, 1 free, 3 stalled never reaches a limit of 4.
    hold_if(3);
    hold_if(3);
    #1;
    check("wdog_3_1_3", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    bus.stallreq_if = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("wdog_after3", 32'(bus.timeout_err), 32'd0);
    @(posedge clk);
    #1;
`ifdef PIPE_STALL_WDOG_EN
    check("wdog_after4", 32'(bus.timeout_err), 32'd1);
`else
    check("wdog_disabled", 32'(bus.timeout_err), 32'd0);
`endif
    @(negedge clk);
    bus.stallreq_if = 1'b0;
    @(negedge clk);
    #1;
`ifdef PIPE_STALL_WDOG_EN
    check("wdog_sticky", 32'(bus.timeout_err), 32'd1);
`else
    check("wdog_disabled_after", 32'(bus.timeout_err), 32'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      set_reqs(vecs[i].s_if, vecs[i].s_id, vecs[i].s_ex, vecs[i].s_mem);
      #1;
      check($sformatf("prio_vec%0d", i), 32'(bus.stall), 32'(vecs[i].exp_stall));
      check($sformatf("prio_busy%0d", i), 32'(bus.busy), 32'd0);
    end
    @(negedge clk);
    clear_all();

    redirect(1'b1, 32'h0000_0040, 1'b0, 32'd0, 32'h40, 32'd0);
    redirect(1'b0, 32'd0, 1'b1, 32'h1000, 32'h1000, 32'h40);
    redirect(1'b1, 32'h0000_0040, 1'b1, 32'h1000, 32'h40, 32'h1000);

    // Requests during FREEZE/FLUSH are ignored.
    @(negedge clk);
    bus.excp_req = 1'b1; bus.excp_vec = 32'h200;
    @(negedge clk);
    bus.excp_vec = 32'h300;
    bus.stallreq_ex = 1'b1;
    #1;
    check("ign_freeze_stall", 32'(bus.stall), 32'h3f);
    @(negedge clk);
    #1;
    check("ign_flush_stall", 32'(bus.stall), 32'd0);
    check("ign_flush_newpc", bus.new_pc, 32'h200);
    check("ign_flush_flush", 32'(bus.flush), 32'd1);
    @(negedge clk);
    clear_all();
    #1;
    check("ign_run_flush", 32'(bus.flush), 32'd0);
    check("ign_run_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    #1;
    check("ign_run2_flush", 32'(bus.flush), 32'd0);
    check("ign_run2_newpc", bus.new_pc, 32'h200);

    // Asynchronous reset during FREEZE drops the pending redirect.
    @(negedge clk);
    bus.eret_req = 1'b1; bus.epc = 32'h4444;
    @(negedge clk);
    clear_all();
    #1;
    check("mid_freeze_busy", 32'(bus.busy), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_stall", 32'(bus.stall), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_flush", 32'(bus.flush), 32'd0);
    check("mid_rst_newpc", bus.new_pc, 32'd0);
    check("mid_rst_npv", 32'(bus.new_pc_valid), 32'd0);
    check("mid_rst_timeout", 32'(bus.timeout_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("post_rst_flush%0d", k), 32'(bus.flush), 32'd0);
      check($sformatf("post_rst_busy%0d", k), 32'(bus.busy), 32'd0);
      check($sformatf("post_rst_npv%0d", k), 32'(bus.new_pc_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
